// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  // Smallest digit count whose decimal range covers every WIDTH-bit value.
  function automatic int min_digits(input int width);
    longint unsigned maxv;
    longint unsigned pow10;
    int d;
    maxv  = (64'd1 << width) - 64'd1;
    pow10 = 64'd1;
    d     = 0;
    for (int i = 0; i < 20; i++) begin
      if (pow10 <= maxv) begin
        pow10 = pow10 * 64'd10;
        d     = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_ctrl_add3.sv
// Single-digit double-dabble correction: digits of five or more get +3.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [BCD_W-1:0] din,
  output logic [BCD_W-1:0] dout
);

  // Correct the digit before the next left shift.
  always_comb begin
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/bin2bcd_seq_ctrl.sv
// Iterative binary-to-BCD converter: one double-dabble step per clock,
// valid/ready on both sides.
module bin2bcd_seq_ctrl
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          bin_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BCD_W*DIGITS-1:0]   bcd_out,
  output logic                      busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = BCD_W * DIGITS;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_CONV = CONV;
  localparam logic [1:0] ST_DONE = DONE;

  generate
    if (WIDTH < 2 || DIGITS < min_digits(WIDTH)) begin : g_param_check
      $fatal(1, "bin2bcd_seq_ctrl: DIGITS too small for WIDTH (or WIDTH < 2)");
    end
  endgenerate

  logic [1:0]       state_r;
  logic [1:0]       state_nx_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] sr_r;
  logic [BW-1:0]    acc_r;
  logic [BW-1:0]    bcd_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic [BW-1:0]    corr_s;
  logic [BW+WIDTH-1:0] pair_s;
  logic             accept_s;
  logic             last_s;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_add3 u_add3 (
        .din  (acc_r[g*BCD_W +: BCD_W]),
        .dout (corr_s[g*BCD_W +: BCD_W])
      );
    end
  endgenerate

  // The corrected accumulator's top bit falls off here; DIGITS guarantees it is zero.
  assign pair_s   = {corr_s, sr_r} << 1;
  assign accept_s = in_valid && in_ready_r;
  assign last_s   = (cnt_r == LAST_ITER);

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nx_s = ST_CONV;
        else          state_nx_s = ST_IDLE;
      end
      ST_CONV: begin
        if (last_s) state_nx_s = ST_DONE;
        else        state_nx_s = ST_CONV;
      end
      ST_DONE: begin
        if (out_ready) state_nx_s = ST_IDLE;
        else           state_nx_s = ST_DONE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, handshake flags and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      sr_r        <= '0;
      acc_r       <= '0;
      bcd_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      in_ready_r  <= (state_nx_s == ST_IDLE);
      out_valid_r <= (state_nx_s == ST_DONE);
      busy_r      <= (state_nx_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            sr_r  <= bin_in;
            acc_r <= '0;
            cnt_r <= '0;
          end
        end
        ST_CONV: begin
          sr_r  <= pair_s[WIDTH-1:0];
          acc_r <= pair_s[BW+WIDTH-1:WIDTH];
          cnt_r <= cnt_r + CW'(1);
          // The output register only moves on entry to DONE, so it never toggles mid-conversion.
          if (last_s) bcd_r <= pair_s[BW+WIDTH-1:WIDTH];
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign bcd_out   = bcd_r;

endmodule

// File: doc/bin2bcd_seq_ctrl.md
# bin2bcd_seq_ctrl

Sequential binary-to-BCD converter controller. It accepts one unsigned binary word per transaction over a valid/ready handshake and runs the shift-add-3 (double-dabble) algorithm one bit per clock. It returns packed BCD digits over a second valid/ready handshake. It replaces the wide combinational compare/subtract ladder for operand widths where that ladder does not scale, and it feeds the display/formatting path downstream.

## Interface
Parameters:
- WIDTH, 8, binary operand width in bits (≥ 2).
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH − 1, otherwise elaboration fails with a fatal error.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  bin_in holds a request.
- in_ready  out  1  controller can accept a request.
- bin_in  in  WIDTH  unsigned binary operand.
- out_valid  out  1  bcd_out holds a completed result.
- out_ready  in  1  consumer accepts the result.
- bcd_out  out  4*DIGITS  packed BCD; bits [3:0] are the units digit, [7:4] the tens digit, and so on.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, CONV, DONE.
- IDLE
  - in_ready = 1.
  - On in_valid & in_ready, capture bin_in into the shift register, clear the BCD accumulator, clear the iteration counter and go to CONV.
- CONV
  - Each cycle, apply the add-3 correction in parallel to every accumulator digit: a digit ≥ 5 gets +3, mod 16.
  - Then shift {accumulator, shift register} left by 1, so the operand MSB enters the accumulator LSB.
  - Increment the counter. After the WIDTH-th iteration go to DONE.
  - Counter width is $clog2(WIDTH+1).
- DONE
  - out_valid = 1. bcd_out presents the accumulator, held stable until handshake.
  - On out_ready, go to IDLE.
- Outside DONE, bcd_out holds its last value. It must not toggle during CONV, so the accumulator and output register are separate.
- in_valid is ignored outside IDLE. bin_in is sampled only on the accept edge and may change afterwards.
- No error path: the DIGITS parameter check makes overflow impossible.

## Timing
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, bcd_out = 0, counter = 0, accumulator = 0.
- Accept edge E0. Iterations occur on edges E1..E_WIDTH. out_valid rises after E_WIDTH, i.e. exactly WIDTH cycles after E0 (8 for defaults).
- The result handshake completes on the edge where out_valid & out_ready are both high. in_ready rises in the following cycle.
- There is no accept in the same cycle as the result handshake. Minimum initiation interval is WIDTH+2 cycles.
- out_ready held high before DONE is legal. The handshake then completes on the first DONE edge.
- out_ready low holds DONE indefinitely. bcd_out and out_valid stay stable, and in_ready stays 0.
- busy is high from the cycle after E0 through the result handshake edge.
- Reset asserted mid-CONV or in DONE:
  - Abort immediately and asynchronously. All outputs return to their reset values.
  - The in-flight result is discarded and never presented.
  - After rst_n deasserts, the first accept is possible on the next rising edge.

## Structure
- Package bin2bcd_pkg:
  - state enum typedef (IDLE, CONV, DONE);
  - function min_digits(width) used for the DIGITS legality check;
  - localparam for the BCD digit width (4).
- Sub-module bcd_add3: 4-bit combinational digit correction (in ≥ 5 ? in+3 : in). Instantiated DIGITS times via generate.
- Top holds the FSM, counter, shift register, accumulator and output register.

## Test plan
- Defaults, bin_in = 255 with out_ready = 1: bcd_out = 12'h255, out_valid exactly 8 cycles after the accept edge, in_ready = 0 and busy = 1 throughout.
- Boundaries 0, 9, 10, 99, 100: results 12'h000, 12'h009, 12'h010, 12'h099, 12'h100. bin_in is changed to 8'hFF right after each accept, and the results must be unaffected.
- Backpressure on 137: out_ready held low for 5 cycles in DONE. bcd_out stays 12'h137, out_valid stays 1, and in_valid pulses are ignored. After release, in_ready = 1 the next cycle.
- Reset mid-conversion: accept 200, assert rst_n low after 3 cycles. All outputs go to reset values at once. Then accept 42: bcd_out = 12'h042 with no trace of 200.
- Exhaustive 0..255 back-to-back with random out_ready stalls: each result matches the model {v/100, (v/10)%10, v%10}, and the initiation interval is never below 10 cycles.
- WIDTH = 5, DIGITS = 2, sweep 0..31: 31 gives 8'h31, 20 gives 8'h20, latency 5 cycles. DIGITS = 1 with WIDTH = 5 must fail elaboration.
